// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: state encoding,
// datapath width and the reset NOP word.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    typedef enum logic [1:0] {
        ST_FETCH = S_FETCH,
        ST_DRAIN = S_DRAIN,
        ST_HOLD  = S_HOLD,
        ST_FAULT = S_FAULT
    } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// One-entry output register between instruction memory and decode.
// Flush beats load, load beats consume, so a word can refill a slot being drained.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic            stall,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            busy,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc4
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            consume;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        consume = valid_q & ~stall;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
            pc4_d   = load_pc + 32'd4;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
        end
    end

    // Full and not leaving this cycle: an arriving word would have nowhere to go.
    assign busy        = valid_q & stall;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = pc_q;
    assign instr_pc4   = pc4_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the one-outstanding req/ack handshake
// and applies redirects. State | meaning:
//   FETCH | request at pc outstanding; DRAIN | discard a fetch killed by redirect
//   HOLD  | buffer full and stalled, no request; FAULT | misaligned target, idle
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    output logic        misaligned
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            mem_req_q, mem_req_d;
    logic            mis_q, mis_d;
    logic            ack, buf_load, buf_flush, buf_busy;
    logic [XLEN-1:0] tgt, pc_inc;

    assign ack    = mem_req_q & mem_ack;
    assign tgt    = redirect_pc & 32'hFFFF_FFFE;
    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        mis_d      = mis_q;
        buf_load   = 1'b0;
        buf_flush  = 1'b0;
        if (redirect) begin
            buf_flush = 1'b1;
            pc_d      = tgt;
            mis_d     = redirect_pc[1];
        end
        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    if (mem_req_q && !mem_ack) begin
                        state_d = ST_DRAIN;
                    end else if (redirect_pc[1]) begin
                        state_d   = ST_FAULT;
                        mem_req_d = 1'b0;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = tgt;
                    end
                end else if (ack) begin
                    // A word arriving into a stalled full buffer is dropped and refetched.
                    if (buf_busy) begin
                        state_d   = ST_HOLD;
                        mem_req_d = 1'b0;
                    end else begin
                        buf_load   = 1'b1;
                        pc_d       = pc_inc;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_inc;
                    end
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                end
            end
            ST_DRAIN: begin
                if (ack) begin
                    if (mis_d) begin
                        state_d   = ST_FAULT;
                        mem_req_d = 1'b0;
                    end else begin
                        state_d    = ST_FETCH;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_d;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    if (redirect_pc[1]) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d    = ST_FETCH;
                        mem_req_d  = 1'b1;
                        mem_addr_d = tgt;
                    end
                end else if (!stall) begin
                    state_d    = ST_FETCH;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                end
            end
            ST_FAULT: begin
                if (redirect && !redirect_pc[1]) begin
                    state_d    = ST_FETCH;
                    mem_req_d  = 1'b1;
                    mem_addr_d = tgt;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            mis_q      <= mis_d;
        end
    end

    fetch_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (buf_load),
        .flush       (buf_flush),
        .stall       (stall),
        .load_instr  (mem_rdata),
        .load_pc     (pc_q),
        .busy        (buf_busy),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_pc4   (instr_pc4)
    );

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a program-order stream model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_ctrl;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst, redirect, stall, force_ack;
    logic [31:0] redirect_pc;
    logic        mem_req, mem_ack, instr_valid, misaligned;
    logic [31:0] mem_addr, mem_rdata, instr, instr_pc, instr_pc4;
    int          mem_wait, wait_cnt;

    logic        w_req, w_valid, w_mis;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_pc4(instr_pc4), .misaligned(misaligned)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .redirect(1'b0), .redirect_pc(32'h0),
        .stall(1'b0), .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_req),
        .mem_rdata(w_addr ^ KEY), .instr_valid(w_valid), .instr(w_instr),
        .instr_pc(w_pc), .instr_pc4(w_pc4), .misaligned(w_mis)
    );

    // Memory: mem[a] = a ^ KEY, acks after mem_wait cycles of a held request.
    assign mem_ack   = (mem_req && wait_cnt >= mem_wait) || force_ack;
    assign mem_rdata = mem_addr ^ KEY;

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Stream model: decode must see pc, pc+4, ... restarting at each redirect target.
    logic [31:0] exp_pc   = 32'h0;
    logic        exp_mis  = 1'b0;
    logic        prev_rst = 1'b0, prev_hold = 1'b0, prev_pend = 1'b0;
    logic [31:0] prev_instr, prev_ipc, prev_addr;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc    = 32'h0;
            exp_mis   = 1'b0;
            prev_rst  = 1'b1;
            prev_hold = 1'b0;
            prev_pend = 1'b0;
        end else begin
            if (prev_rst) begin
                chk("rst_req",   mem_req,     32'h0);
                chk("rst_valid", instr_valid, 32'h0);
                chk("rst_instr", instr,       32'h0000_0013);
                chk("rst_pc",    instr_pc,    32'h0);
                chk("rst_pc4",   instr_pc4,   32'h0);
                chk("rst_mis",   misaligned,  32'h0);
            end
            chk("misaligned", misaligned, exp_mis);
            if (exp_mis) begin
                chk("valid_in_fault", instr_valid, 32'h0);
                if (!prev_pend) chk("req_in_fault", mem_req, 32'h0);
            end
            if (prev_hold) begin
                chk("hold_valid", instr_valid, 32'h1);
                chk("hold_instr", instr, prev_instr);
                chk("hold_pc", instr_pc, prev_ipc);
            end
            if (prev_pend) begin
                chk("req_held", mem_req, 32'h1);
                chk("addr_held", mem_addr, prev_addr);
            end
            if (instr_valid && !stall) begin
                chk("stream_pc", instr_pc, exp_pc);
                chk("stream_instr", instr, exp_pc ^ KEY);
                chk("stream_pc4", instr_pc4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
            end
            prev_hold  = instr_valid && stall && !redirect;
            prev_instr = instr;
            prev_ipc   = instr_pc;
            prev_pend  = mem_req && !mem_ack;
            prev_addr  = mem_addr;
            if (redirect) begin
                exp_pc  = redirect_pc & 32'hFFFF_FFFE;
                exp_mis = redirect_pc[1];
            end
            prev_rst = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; stall = 1'b0; force_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (instr_valid) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_req(input logic [31:0] a, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (mem_req && mem_addr == a) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        force_ack = 1'b0; mem_wait = 0;

        // Zero-wait streaming, plus wrap-around on the second instance
        do_reset();
        chk("p1_c0_req", mem_req, 32'h0);
        chk("p1_c0_valid", instr_valid, 32'h0);
        chk("p1_c0_instr", instr, 32'h0000_0013);
        tick();
        chk("p1_c1_req", mem_req, 32'h1);
        chk("p1_c1_addr", mem_addr, 32'h0);
        chk("p1_c1_valid", instr_valid, 32'h0);
        tick();
        chk("p1_c2_valid", instr_valid, 32'h1);
        chk("p1_c2_pc", instr_pc, 32'h0);
        chk("p1_c2_instr", instr, 32'hA5A5_A5A5);
        chk("p1_c2_pc4", instr_pc4, 32'h4);
        chk("wrap_c2_pc", w_pc, 32'hFFFF_FFF8);
        tick();
        chk("p1_c3_pc", instr_pc, 32'h4);
        chk("wrap_c3_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_c3_pc4", w_pc4, 32'h0);
        tick();
        chk("p1_c4_pc", instr_pc, 32'h8);
        chk("p1_c4_instr", instr, 32'hA5A5_A5AD);
        chk("wrap_c4_pc", w_pc, 32'h0);
        chk("wrap_c4_valid", w_valid, 32'h1);
        repeat (4) tick();

        // 3-wait memory, 5-cycle stall on the first word
        mem_wait = 3;
        do_reset();
        wait_valid(20, ok);
        chk("p2_first_seen", ok, 32'h1);
        chk("p2_first_pc", instr_pc, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("p2_hold_valid", instr_valid, 32'h1);
            chk("p2_hold_pc", instr_pc, 32'h0);
            if (i == 4) chk("p2_hold_req", mem_req, 32'h0);
            tick();
        end
        stall = 1'b0;
        tick();
        chk("p2_refetch_req", mem_req, 32'h1);
        chk("p2_refetch_addr", mem_addr, 32'h4);
        wait_valid(20, ok);
        chk("p2_second_seen", ok, 32'h1);
        chk("p2_second_pc", instr_pc, 32'h4);
        repeat (3) tick();

        // Redirect while a 3-wait fetch of 0x8 is outstanding
        mem_wait = 3;
        do_reset();
        wait_req(32'h8, 30, ok);
        chk("p3_req8_seen", ok, 32'h1);
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        chk("p3_drain_req", mem_req, 32'h1);
        chk("p3_drain_addr", mem_addr, 32'h8);
        wait_req(32'h100, 20, ok);
        chk("p3_req100_seen", ok, 32'h1);
        wait_valid(20, ok);
        chk("p3_valid_seen", ok, 32'h1);
        chk("p3_valid_pc", instr_pc, 32'h100);
        repeat (3) tick();

        // Misaligned redirect coincident with an ack, then recovery
        mem_wait = 0;
        do_reset();
        repeat (3) tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        chk("p4_mis_set", misaligned, 32'h1);
        chk("p4_fault_req", mem_req, 32'h0);
        chk("p4_fault_valid", instr_valid, 32'h0);
        repeat (3) tick();
        chk("p4_mis_sticky", misaligned, 32'h1);
        chk("p4_fault_req_late", mem_req, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        tick();
        redirect = 1'b0;
        chk("p4_mis_clear", misaligned, 32'h0);
        chk("p4_resume_req", mem_req, 32'h1);
        chk("p4_resume_addr", mem_addr, 32'h300);
        wait_valid(10, ok);
        chk("p4_valid_seen", ok, 32'h1);
        chk("p4_valid_pc", instr_pc, 32'h300);
        chk("p4_valid_instr", instr, 32'hA5A5_A6A5);
        repeat (3) tick();

        // Reset during DRAIN with a late ack right after
        mem_wait = 3;
        do_reset();
        wait_req(32'h4, 30, ok);
        chk("p6_req4_seen", ok, 32'h1);
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        redirect = 1'b0;
        chk("p6_drain_addr", mem_addr, 32'h4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        force_ack = 1'b1;
        chk("p6_rst_req", mem_req, 32'h0);
        chk("p6_rst_valid", instr_valid, 32'h0);
        tick();
        force_ack = 1'b0;
        chk("p6_c1_valid", instr_valid, 32'h0);
        chk("p6_c1_req", mem_req, 32'h1);
        chk("p6_c1_addr", mem_addr, 32'h0);
        wait_valid(20, ok);
        chk("p6_valid_seen", ok, 32'h1);
        chk("p6_valid_pc", instr_pc, 32'h0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
